// File: rtl/index_to_rgb_symbol_tx_if.sv
// Symbol input stream: one colour index plus its duration per valid/ready transfer.
interface index_to_rgb_symbol_tx_if #(
    parameter int BITS_PER_AXIS = 2,
    parameter int CNT_W         = 16
);
    logic                         in_valid;
    logic                         in_ready;
    logic [3*BITS_PER_AXIS-1:0]   in_index;
    logic [CNT_W-1:0]             sym_len;

    modport master (
        output in_valid,
        output in_index,
        output sym_len,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_index,
        input  sym_len,
        output in_ready
    );
endinterface

// File: rtl/index_to_rgb_symbol_tx.sv
// Maps a 3-axis amplitude index onto programmable R/G/B level tables and drives the
// resulting colour for a configurable number of cycles, back-to-back when fed continuously.
module index_to_rgb_symbol_tx #(
    parameter int BITS_PER_AXIS = 2,
    parameter int OUT_W         = 8,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    index_to_rgb_symbol_tx_if.slave  sym_if,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_axis,
    input  logic [BITS_PER_AXIS-1:0] cfg_level,
    input  logic [OUT_W-1:0]         cfg_data,
    output logic [OUT_W-1:0]         R_out,
    output logic [OUT_W-1:0]         G_out,
    output logic [OUT_W-1:0]         B_out,
    output logic                     sym_active,
    output logic                     sym_start
);
    localparam int LEVELS = 1 << BITS_PER_AXIS;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0] OUT_ZERO = {OUT_W{1'b0}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Evenly spaced full-scale ramp: entry k = floor(k * (2^OUT_W - 1) / (LEVELS - 1)).
    function automatic logic [OUT_W-1:0] default_level(input int k);
        logic [63:0] full_scale;
        logic [63:0] scaled;
        full_scale = (64'd1 << OUT_W) - 64'd1;
        scaled     = (64'(k) * full_scale) / 64'(LEVELS - 1);
        return scaled[OUT_W-1:0];
    endfunction

    logic [OUT_W-1:0] tbl_red_r [LEVELS];
    logic [OUT_W-1:0] tbl_grn_r [LEVELS];
    logic [OUT_W-1:0] tbl_blu_r [LEVELS];

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [OUT_W-1:0] red_r, grn_r, blu_r;
    logic [OUT_W-1:0] red_nxt_s, grn_nxt_s, blu_nxt_s;
    logic             active_r, active_nxt_s;
    logic             start_r, start_nxt_s;

    logic                     in_ready_s;
    logic                     accept_s;
    logic                     do_load_s;
    logic                     do_clear_s;
    logic [CNT_W-1:0]         len_m1_s;
    logic [BITS_PER_AXIS-1:0] lvl_red_s, lvl_grn_s, lvl_blu_s;

    assign lvl_red_s = sym_if.in_index[BITS_PER_AXIS-1:0];
    assign lvl_grn_s = sym_if.in_index[2*BITS_PER_AXIS-1:BITS_PER_AXIS];
    assign lvl_blu_s = sym_if.in_index[3*BITS_PER_AXIS-1:2*BITS_PER_AXIS];

    // Ready in IDLE or on the final HOLD cycle, so a new symbol can follow with no gap.
    assign in_ready_s    = ~reset & ((state_r == IDLE) | (cnt_r == CNT_ZERO));
    assign accept_s      = sym_if.in_valid & in_ready_s;
    assign len_m1_s      = (sym_if.sym_len == CNT_ZERO) ? CNT_ZERO : (sym_if.sym_len - CNT_ONE);
    assign sym_if.in_ready = in_ready_s;

    // Level tables: reset to the default ramp, otherwise written by the cfg port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LEVELS; k++) begin
                tbl_red_r[k] <= default_level(k);
                tbl_grn_r[k] <= default_level(k);
                tbl_blu_r[k] <= default_level(k);
            end
        end else if (cfg_we) begin
            case (cfg_axis)
                2'd0:    tbl_red_r[cfg_level] <= cfg_data;
                2'd1:    tbl_grn_r[cfg_level] <= cfg_data;
                2'd2:    tbl_blu_r[cfg_level] <= cfg_data;
                default: begin end
            endcase
        end
    end

    // Symbol FSM next-state and output-register next values.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        red_nxt_s    = red_r;
        grn_nxt_s    = grn_r;
        blu_nxt_s    = blu_r;
        active_nxt_s = active_r;
        start_nxt_s  = 1'b0;
        do_load_s    = 1'b0;
        do_clear_s   = 1'b0;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    do_load_s = 1'b1;
                end else begin
                    do_clear_s = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else if (accept_s) begin
                    do_load_s = 1'b1;
                end else begin
                    do_clear_s = 1'b1;
                end
            end
            default: begin
                do_clear_s = 1'b1;
            end
        endcase

        // Colours are sampled from the tables before any same-edge table write lands.
        if (do_load_s) begin
            state_nxt_s  = HOLD;
            cnt_nxt_s    = len_m1_s;
            red_nxt_s    = tbl_red_r[lvl_red_s];
            grn_nxt_s    = tbl_grn_r[lvl_grn_s];
            blu_nxt_s    = tbl_blu_r[lvl_blu_s];
            active_nxt_s = 1'b1;
            start_nxt_s  = 1'b1;
        end else if (do_clear_s) begin
            state_nxt_s  = IDLE;
            cnt_nxt_s    = CNT_ZERO;
            red_nxt_s    = OUT_ZERO;
            grn_nxt_s    = OUT_ZERO;
            blu_nxt_s    = OUT_ZERO;
            active_nxt_s = 1'b0;
        end else begin
            start_nxt_s  = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            red_r    <= OUT_ZERO;
            grn_r    <= OUT_ZERO;
            blu_r    <= OUT_ZERO;
            active_r <= 1'b0;
            start_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            red_r    <= red_nxt_s;
            grn_r    <= grn_nxt_s;
            blu_r    <= blu_nxt_s;
            active_r <= active_nxt_s;
            start_r  <= start_nxt_s;
        end
    end

    assign R_out      = red_r;
    assign G_out      = grn_r;
    assign B_out      = blu_r;
    assign sym_active = active_r;
    assign sym_start  = start_r;
endmodule

// File: doc/index_to_rgb_symbol_tx.md
INDEX_TO_RGB_SYMBOL_TX -- requirements
Module: index_to_rgb_symbol_tx

Interface
REQ-001 Parameter BITS_PER_AXIS, default 2: amplitude-index bits per colour axis; LEVELS = 2^BITS_PER_AXIS.
REQ-002 Parameter OUT_W, default 8: width of each colour output and each level-table entry.
REQ-003 Parameter CNT_W, default 16: width of the symbol-length counter and the sym_len input.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  in_index holds a symbol to transmit.
REQ-008 in_ready  output  1  block accepts in_index this cycle; transfer occurs when in_valid & in_ready.
REQ-009 in_index  input  3*BITS_PER_AXIS  symbol; R level in [B-1:0], G in [2B-1:B], B in [3B-1:2B] (B = BITS_PER_AXIS).
REQ-010 sym_len  input  CNT_W  symbol duration in clk cycles, sampled at acceptance; 0 treated as 1.
REQ-011 cfg_we  input  1  level-table write strobe.
REQ-012 cfg_axis  input  2  table select: 0=R, 1=G, 2=B, 3=no write.
REQ-013 cfg_level  input  BITS_PER_AXIS  entry written.
REQ-014 cfg_data  input  OUT_W  value written.
REQ-015 R_out, G_out, B_out  output  OUT_W each  registered colour drive.
REQ-016 sym_active  output  1  high while a symbol is driven.
REQ-017 sym_start  output  1  one-cycle pulse on the first cycle of every symbol.

Function
REQ-018 Three tables (R, G, B) of LEVELS x OUT_W registers SHALL hold amplitude levels; reset value of entry k = floor(k*(2^OUT_W-1)/(LEVELS-1)) (defaults 0, 85, 170, 255).
REQ-019 cfg_we=1 with cfg_axis 0-2 SHALL write cfg_data into the selected entry at the clock edge; cfg_axis=3 SHALL write nothing.
REQ-020 FSM states: IDLE, HOLD.
REQ-021 IDLE: in_ready=1, sym_active=0, outputs 0; on transfer go to HOLD.
REQ-022 On transfer at edge N, from cycle N+1: R/G/B_out = table values of the indexed levels, sym_active=1, sym_start=1 for that cycle only; counter loaded with max(sym_len,1)-1.
REQ-023 HOLD: counter decrements each cycle; outputs held constant; in_ready=1 only on the last cycle (counter==0), else 0.
REQ-024 Last HOLD cycle with transfer: next symbol starts on the next cycle, no gap (back-to-back), sym_start pulses again.
REQ-025 Last HOLD cycle with no transfer: return to IDLE; outputs go to 0 on the next cycle.
REQ-026 Colour values SHALL be captured from the tables at acceptance; table writes during HOLD SHALL NOT change the symbol being driven.
REQ-027 Table write and acceptance reading the same entry in the same cycle: the symbol SHALL use the pre-write value.
REQ-028 sym_len changes during HOLD SHALL NOT affect the current symbol.
REQ-029 Symbol duration SHALL be exactly max(sym_len,1) cycles of sym_active=1; sym_len=2^CNT_W-1 SHALL not wrap early.
REQ-030 in_index and sym_len SHALL be ignored when no transfer occurs.

Reset
REQ-031 reset=1 at an edge SHALL force IDLE, counter 0, R/G/B_out=0, sym_active=0, sym_start=0, and all table entries to REQ-018 defaults, overriding any concurrent write or transfer.
REQ-032 in_ready SHALL be 0 while reset=1.
REQ-033 Reset asserted mid-symbol SHALL abort it; outputs 0 from the cycle after the reset edge.

Verification
REQ-034 Defaults: after reset, index=6'b11_10_01, sym_len=3, one transfer -> R=85, G=170, B=255 for exactly 3 cycles, sym_start on first, then all 0, sym_active=0.
REQ-035 Back-to-back: in_valid held, indices 6'h3F then 6'h00, sym_len=2 -> 255/255/255 for 2 cycles then 0/0/0 with sym_active=1 for 2 cycles, no gap, two sym_start pulses, in_ready high only on cycle 2 of each symbol.
REQ-036 Table write: write G level 1 = 8'd42, then send index 6'b00_01_00, sym_len=1 -> G_out=42 for 1 cycle; write same entry in acceptance cycle -> old value used.
REQ-037 Mid-symbol write: during a sym_len=5 symbol using R level 3, write R level 3 = 8'd7 -> R_out stays 255 for all 5 cycles; next symbol shows 7.
REQ-038 sym_len=0 -> one-cycle symbol; reset asserted on cycle 2 of a sym_len=10 symbol -> outputs 0 next cycle, table back to 0/85/170/255.
